// File: rtl/div_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq_unit
//  Purpose  : Iterative restoring divider for the HI/LO register pair.
//             One quotient bit per clock, signed/unsigned per operation,
//             divide-by-zero and signed-overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,      // synchronous, active low
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             signed_q, signed_d;
  logic             neg_dvd_q, neg_dvd_d;   // dividend was negative
  logic             neg_dvs_q, neg_dvs_d;   // divisor was negative
  logic [WIDTH:0]   rem_q, rem_d;           // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_q, quo_d;           // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvs_q, dvs_d;           // divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Operand magnitudes: two's complement only for negative signed operands
  logic             w_dvd_neg, w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  // One restoring step
  logic [WIDTH:0]   w_shift, w_trial;
  // Sign correction of the final magnitudes
  logic [WIDTH-1:0] w_quo_res, w_rem_res;
  logic             w_ovf;

  // Operand preparation, restoring step and sign fix-up datapath
  always_comb begin
    w_dvd_neg = signed_op & dividend[WIDTH-1];
    w_dvs_neg = signed_op & divisor[WIDTH-1];
    w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    w_shift   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    w_trial   = w_shift - {1'b0, dvs_q};

    w_quo_res = (signed_q & (neg_dvd_q ^ neg_dvs_q)) ? (~quo_q + 1'b1) : quo_q;
    w_rem_res = (signed_q & neg_dvd_q) ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    // A same-sign signed quotient with its MSB set can only be MIN / -1;
    // the wrapped result already equals MIN, so only the flag is needed.
    w_ovf     = signed_q & ~(neg_dvd_q ^ neg_dvs_q) & quo_q[WIDTH-1];
  end

  // Next-state and register-update logic for the control FSM
  always_comb begin
    state_d   = state_q;
    signed_d  = signed_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          signed_d  = signed_op;
          neg_dvd_d = w_dvd_neg;
          neg_dvs_d = w_dvs_neg;
          rem_d     = '0;
          quo_d     = w_dvd_mag;
          dvs_d     = w_dvs_mag;
          cnt_d     = '0;
          if (divisor == '0) begin
            hi_d    = '0;
            lo_d    = '0;
            div0_d  = 1'b1;
            ovf_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (w_trial[WIDTH]) begin
          rem_d = w_shift;
        end else begin
          rem_d = w_trial;
        end
        quo_d = {quo_q[WIDTH-2:0], ~w_trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        hi_d    = w_rem_res;
        lo_d    = w_quo_res;
        div0_d  = 1'b0;
        ovf_d   = w_ovf;
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      signed_q  <= 1'b0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      signed_q  <= signed_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // done is a registered pulse, so busy covers the active states plus that pulse
  assign busy     = (state_q != S_IDLE) | done_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div0     = div0_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq_unit
//  Purpose  : Scoreboard bench for div_seq_unit (WIDTH=32 and WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_seq_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, sop;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, d0, ov;
  logic        start8, sop8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, d08, ov8;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        d0;
    logic        ov;
    int unsigned at;
  } exp_t;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          d0;
    bit          ov;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];

  div_seq_unit #(.WIDTH(32)) u_dut (
    .clock(clock), .reset(reset), .start(start), .signed_op(sop),
    .dividend(a), .divisor(b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div0(d0), .overflow(ov)
  );

  div_seq_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_op(sop8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8), .div0(d08), .overflow(ov8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drive one 32-bit request at the current negedge and queue its expectation
  task automatic issue(input bit s, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input bit ed0, input bit eov);
    exp_t e;
    start = 1'b1; sop = s; a = x; b = y;
    e.lo = elo; e.hi = ehi; e.d0 = ed0; e.ov = eov;
    e.at = cyc + ((y == 32'd0) ? 32'd2 : 32'd35);
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 80) begin
      @(negedge clock);
      k++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run8(input bit s, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] elo, input logic [7:0] ehi, input bit eov);
    int unsigned t0;
    int k = 0;
    start8 = 1'b1; sop8 = s; a8 = x; b8 = y;
    t0 = cyc;
    @(negedge clock);
    start8 = 1'b0;
    while (!done8 && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("w8_done_seen", {31'd0, done8}, 32'd1);
    chk("w8_done_cycle", cyc, t0 + 32'd11);
    chk("w8_lo", {24'd0, lo8}, {24'd0, elo});
    chk("w8_hi", {24'd0, hi8}, {24'd0, ehi});
    chk("w8_overflow", {31'd0, ov8}, {31'd0, eov});
    @(negedge clock);
  endtask

  initial begin
    exp_t e;
    bit   seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'd55,         32'd0,          32'd0,          32'd0,          1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 1'b0};

    reset = 1'b0; start = 1'b1; sop = 1'b0; a = 32'd5; b = 32'd1;
    start8 = 1'b0; sop8 = 1'b0; a8 = 8'd0; b8 = 8'd0;

    fork
      begin : monitor
        forever begin
          @(negedge clock);
          if (done) begin
            if (sb.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
              e = sb.pop_front();
              chk("lo",         lo,               e.lo);
              chk("hi",         hi,               e.hi);
              chk("div0",       {31'd0, d0},      {31'd0, e.d0});
              chk("overflow",   {31'd0, ov},      {31'd0, e.ov});
              chk("done_cycle", cyc,              e.at);
              chk("busy_at_done", {31'd0, busy},  32'd1);
            end
          end
        end
      end
    join_none

    // Reset held with start asserted: reset must win
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi",   hi, 32'd0);
    chk("rst_lo",   lo, 32'd0);
    chk("rst_div0", {31'd0, d0}, 32'd0);
    chk("rst_ovf",  {31'd0, ov}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].d0, vecs[i].ov);
      wait_done();
      @(negedge clock);
      chk("done_pulse_end", {31'd0, done}, 32'd0);
      chk("busy_idle",      {31'd0, busy}, 32'd0);
    end

    // Starts during CALC are ignored; previous result held meanwhile
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    chk("hold_lo", lo, 32'h8000_0000);
    chk("hold_hi", hi, 32'd0);
    for (int i = 0; i < 8; i++) begin
      start = 1'b1; sop = i[0]; a = 32'd999 + i; b = (i == 3) ? 32'd0 : 32'd3;
      @(negedge clock);
    end
    start = 1'b0;
    wait_done();

    // Start in the done cycle is accepted
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_done();
    @(negedge clock);

    // Reset in the middle of CALC aborts the operation
    start = 1'b1; sop = 1'b0; a = 32'd12345; b = 32'd11;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi",   hi, 32'd0);
    chk("abort_lo",   lo, 32'd0);
    chk("abort_div0", {31'd0, d0}, 32'd0);
    chk("abort_ovf",  {31'd0, ov}, 32'd0);
    reset = 1'b1;
    seen = 1'b0;
    repeat (45) begin
      @(negedge clock);
      seen = seen | done;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);

    // WIDTH=8 instance
    run8(1'b0, 8'd200, 8'd3,   8'd66,  8'd2,   1'b0);
    run8(1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b1);
    run8(1'b1, 8'h80,  8'd3,   8'hD6,  8'hFE,  1'b0);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_seq_unit.md
# div_seq_unit

Parametrised iterative integer divider for the datapath's HI/LO register pair, computing one quotient bit per clock by restoring division. It adds a start/busy/done handshake, per-operation signed/unsigned mode, overflow detection and a configurable width. The control unit issues `start` and stalls on `busy`, then writes `hi`/`lo` to HI/LO when `done` pulses.

## Interface
- `WIDTH`, 32, operand and result width in bits, at least 4.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `signed_op`  in  1  1 = two's-complement division, 0 = unsigned; sampled with `start`.
- `dividend`  in  WIDTH  numerator; sampled with `start`.
- `divisor`  in  WIDTH  denominator; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse; `hi`, `lo` and the flags are valid from this cycle.
- `hi`  out  WIDTH  remainder.
- `lo`  out  WIDTH  quotient.
- `div0`  out  1  last operation had a zero divisor.
- `overflow`  out  1  last operation was signed most-negative / -1.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE + `start`=1:
  - latch `signed_op`, the operand signs and the operand magnitudes;
  - clear the iteration counter;
  - go to CALC, or to DONE when `divisor`==0.
- In IDLE, `start`=0 holds state and outputs. In any other state `start` is ignored and nothing is queued.
- Magnitude rule: when `signed_op`=1 and the operand MSB=1, the magnitude is the two's complement of the operand. Otherwise the operand is used as-is.
- CALC runs for exactly WIDTH cycles. Each cycle:
  - shift the (WIDTH+1)-bit partial remainder left, bringing in the next dividend bit, MSB first;
  - trial-subtract the divisor magnitude;
  - if the result is non-negative, keep it and shift in quotient bit 1, otherwise shift in 0.
- FIX (1 cycle), signed mode only:
  - quotient is negated when the operand signs differ (truncation toward zero);
  - remainder is negated when the dividend is negative, so the remainder takes the dividend's sign;
  - `hi`, `lo`, `div0`=0 and `overflow` are registered here.
- Overflow: `signed_op`=1, `dividend`=1 followed by WIDTH-1 zeros (the most-negative value), `divisor`=all ones. Result is `lo`=the most-negative value, `hi`=0, `overflow`=1. The natural wrap of the algorithm gives this; no special path is needed.
- Divide by zero: skip CALC and FIX. Register `hi`=0, `lo`=0, `div0`=1, `overflow`=0.
- DONE (1 cycle): `done`=1, `busy`=1. Always returns to IDLE.
- `hi`, `lo`, `div0` and `overflow` hold until the next result is registered. They do not change while a later operation is in CALC.
- Unsigned mode never sets `overflow`. Any bit pattern is a valid unsigned operand.

## Timing
- Reset (`reset`=0 at an edge): state goes to IDLE and `busy`, `done`, `hi`, `lo`, `div0`, `overflow` all go to 0. Reset wins over a simultaneous `start`.
- Reset asserted mid-operation aborts the operation; no `done` is produced.
- Take `start` sampled at edge T0 in IDLE:
  - normal case: CALC covers edges T1..T_WIDTH, FIX is edge T_WIDTH+1, `done`=1 in the cycle after edge T_WIDTH+2 (WIDTH+2 edges after T0). For WIDTH=32, `done` comes 34 cycles after `start`;
  - zero divisor: `done`=1 in the cycle after edge T1.
- `busy` rises after T0 and falls with the IDLE entry that follows `done`.
- A new `start` is accepted at the edge that ends the `done` cycle (IDLE is re-entered at that edge). Back-to-back operations therefore have a period of WIDTH+3 cycles.
- The operand inputs may change freely after T0.

## Test plan
- Unsigned, WIDTH=32, 100 / 7 -> `lo`=14, `hi`=2, `done` exactly 34 cycles after `start`, `busy` high throughout. Also 0xFFFFFFFF / 0x10 -> `lo`=0x0FFFFFFF, `hi`=0xF.
- Signed sign combinations: -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. 7/-2 -> `lo`=0xFFFFFFFD, `hi`=1. -7/-2 -> `lo`=3, `hi`=0xFFFFFFFF. The same -7 bit pattern (0xFFFFFFF9) divided by 2 with `signed_op`=0 -> `lo`=0x7FFFFFFC, `hi`=1.
- Signed 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0, `overflow`=1, `div0`=0. The same operands with `signed_op`=0 -> `lo`=0, `hi`=0x80000000, `overflow`=0.
- Divisor 0, dividend 55 -> `done` one cycle after the start edge, `div0`=1, `hi`=`lo`=0. The next valid operation clears `div0`.
- Send `start` with new operands every cycle during CALC -> all are ignored; the original result is unchanged. A `start` in the `done` cycle is accepted and its `done` follows WIDTH+3 cycles later.
- Drive `reset`=0 at CALC cycle 10 -> all outputs 0, no `done`, IDLE. Repeat with WIDTH=8: 200/3 unsigned -> `lo`=66, `hi`=2, `done` 10 cycles after `start`.
